// File: rtl/dmem_responder_pkg.sv
// -----------------------------------------------------------------------------
// dmem_responder_pkg
// Shared encodings for the data-memory responder and its lane aligner:
//   ls_bit_e   - access size as carried on the load/store port
//   exception codes reported with address errors
//   state_e    - responder FSM state encoding
//   dmem_req_t - one captured load/store request
// -----------------------------------------------------------------------------
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        LS_NONE = 2'b00,
        LS_WORD = 2'b01,
        LS_HALF = 2'b10,
        LS_BYTE = 2'b11
    } ls_bit_e;

    localparam logic [3:0] NO_EXC = 4'd0;
    localparam logic [3:0] ADEL   = 4'd4;   // load address error
    localparam logic [3:0] ADES   = 4'd5;   // store address error

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        ls_bit_e     ls;
        logic        sgn;
        logic [31:0] wdata;
    } dmem_req_t;

    // HALF must sit on an even byte, WORD on a multiple of four.
    function automatic logic is_misaligned(input ls_bit_e ls, input logic [1:0] lo);
        case (ls)
            LS_WORD: return lo != 2'b00;
            LS_HALF: return lo[0];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// -----------------------------------------------------------------------------
// dmem_lane_align
// Combinational byte/half/word lane steering for one 32-bit RAM word
// (little-endian).
//   word_i       - current RAM word at the access index
//   addr_lo_i    - byte offset within the word
//   ls_bit_i     - access size
//   signed_i     - sign-extend HALF/BYTE loads
//   wdata_i      - right-justified store data
//   load_data_o  - extended load result (0 when misaligned or NONE)
//   store_word_o - word_i with the store lanes merged in (word_i if misaligned)
//   misalign_o   - access is not naturally aligned
// -----------------------------------------------------------------------------
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_lo_i,
    input  ls_bit_e     ls_bit_i,
    input  logic        signed_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] store_word_o,
    output logic        misalign_o
);

    logic [4:0]  sh;     // bit offset of the addressed lane
    logic [31:0] lane;   // word shifted so the addressed lane sits at bit 0
    logic [31:0] mask;   // RAM bits a store replaces

    always_comb begin
        sh          = {addr_lo_i, 3'b000};
        lane        = word_i >> sh;
        misalign_o  = is_misaligned(ls_bit_i, addr_lo_i);
        load_data_o = 32'h0;
        mask        = 32'h0;
        case (ls_bit_i)
            LS_WORD: begin
                load_data_o = word_i;
                mask        = 32'hFFFF_FFFF;
            end
            LS_HALF: begin
                load_data_o = {{16{signed_i & lane[15]}}, lane[15:0]};
                mask        = 32'h0000_FFFF << sh;
            end
            LS_BYTE: begin
                load_data_o = {{24{signed_i & lane[7]}}, lane[7:0]};
                mask        = 32'h0000_00FF << sh;
            end
            default: ;
        endcase
        // A misaligned access neither returns data nor touches any lane.
        if (misalign_o) begin
            load_data_o = 32'h0;
            mask        = 32'h0;
        end
        store_word_o = (word_i & ~mask) | ((wdata_i << sh) & mask);
    end

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Far end of the CPU load/store port: holds the data RAM and answers each
// request after a fixed, configurable latency.
//   clock, reset          - rising-edge clock, async active-low reset
//   req_valid/req_ready   - request handshake (ready only while idle)
//   req_addr/we/ls_bit/signed/wdata - request payload
//   rsp_valid/rsp_ready   - response handshake
//   rsp_rdata/err/exc     - load data, address error flag, exception code
// Parameters: DEPTH words of 32 bits (power of two), LATENCY 1..15.
//
// The access commits (RAM write / read-data capture) on the edge that raises
// rsp_valid. Counting the accepting edge as the first, that is edge number
// LATENCY, so one access completes every LATENCY+1 cycles when the consumer
// is always ready.
// -----------------------------------------------------------------------------
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [1:0]  req_ls_bit,
    input  logic        req_signed,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [3:0]  rsp_exc
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    dmem_req_t   req_q, req_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic [3:0]  rsp_exc_q, rsp_exc_d;

    logic [31:0] mem [DEPTH];

    dmem_req_t   acc;        // request being committed
    logic [AW-1:0] acc_idx;
    logic [31:0] word_rd;
    logic [31:0] load_data;
    logic [31:0] store_word;
    logic        misalign;
    logic        accept;
    logic        commit;
    logic        mem_we;
    logic        addr_hi_unused;

    assign req_ready = (state_q == ST_IDLE);
    assign accept    = req_valid && req_ready;

    // With LATENCY==1 the access commits on the accepting edge, so it must
    // come straight from the request port; otherwise from the captured copy.
    always_comb begin
        if (state_q == ST_IDLE) begin
            acc.addr  = req_addr;
            acc.we    = req_we;
            acc.ls    = ls_bit_e'(req_ls_bit);
            acc.sgn   = req_signed;
            acc.wdata = req_wdata;
        end else begin
            acc = req_q;
        end
    end

    // Address bits above the RAM index wrap away.
    assign acc_idx        = acc.addr[AW+1:2];
    assign addr_hi_unused = ^acc.addr[31:AW+2];
    assign word_rd        = mem[acc_idx];

    assign commit = (LATENCY == 1) ? accept
                                   : (state_q == ST_WAIT && cnt_q == 4'd1);

    // Gate with reset so a request presented while held in reset cannot write.
    assign mem_we = commit && reset && acc.we && !misalign && (acc.ls != LS_NONE);

    dmem_lane_align u_align (
        .word_i       (word_rd),
        .addr_lo_i    (acc.addr[1:0]),
        .ls_bit_i     (acc.ls),
        .signed_i     (acc.sgn),
        .wdata_i      (acc.wdata),
        .load_data_o  (load_data),
        .store_word_o (store_word),
        .misalign_o   (misalign)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        rsp_exc_d   = rsp_exc_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    req_d = acc;
                    if (LATENCY == 1) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d = ST_RESP;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (commit) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = misalign;
            rsp_exc_d   = misalign ? (acc.we ? ADES : ADEL) : NO_EXC;
            rsp_rdata_d = acc.we ? 32'h0 : load_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            req_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
            rsp_exc_q   <= NO_EXC;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_exc_q   <= rsp_exc_d;
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[acc_idx] <= store_word;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_exc   = rsp_exc_q;

endmodule
